demux_1x4_buf: RTL and testbench
================================

Name: demux_1x4_buf

Overview:
- Registered 1-to-4 demultiplexer; the inverse of the team's 4x1 MUX.
- Accepts one word per cycle on a valid/ready input and steers it, by sel, into one of four single-entry output buffers (A, B, C, D).
- Each output buffer drains through its own valid/ready port.
- Sits between a shared source and four independent consumers.

Parameters:
- WIDTH, 4, data width of input and each output channel.
- CNT_W, 8, width of the accepted-word counter.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  reset: synchronous, active-high.
- in_data  input  WIDTH  input word.
- in_valid  input  1  source has a word.
- in_ready  output  1  block accepts the word this cycle.
- sel  input  2  destination: 0=A, 1=B, 2=C, 3=D.
- en  input  1  input enable; 0 blocks acceptance.
- a_data, b_data, c_data, d_data  output  WIDTH  per-channel buffered word.
- a_valid, b_valid, c_valid, d_valid  output  1  per-channel buffer full.
- a_ready, b_ready, c_ready, d_ready  input  1  per-channel consumer ready.
- word_cnt  output  CNT_W  count of accepted input words.

Behaviour:
- State:
  - data_q[0..3] (WIDTH each)
  - valid_q[0..3]
  - word_cnt
  - rr_q (feature only)
- Reset (rst=1 at posedge): all valid_q=0, all data_q=0, word_cnt=0, rr_q=0. Reset has priority over every other event.
- Reset mid-operation: buffered words are discarded; valid outputs are low the cycle after the reset edge.
- Destination index: dst = sel (or rr_q, see Optional Feature).
- in_ready (combinational) = en & (!valid_q[dst] | ready_i[dst]).
- Accept condition: in_valid & in_ready at posedge.
  - On accept: data_q[dst] <= in_data, valid_q[dst] <= 1, word_cnt <= word_cnt+1.
- Latency: a word accepted at edge N appears on x_valid/x_data after edge N; one cycle.
- Drain: a channel with valid_q[i] & ready_i[i] at posedge clears valid_q[i], unless the same edge loads that channel.
- Simultaneous load and drain on the same channel: valid_q stays 1 and data_q takes the new word. Full throughput of 1 word/cycle is sustained to one channel.
- Loads and drains on different channels in the same cycle are independent. Only one channel loads per cycle.
- Drain-only channels are unaffected by sel.
- Stall: while in_valid & !in_ready, the source holds in_data and sel stable. The block does not latch anything while stalled.
- Output stability: while x_valid=1 and x_ready=0, x_data is held constant.
- When x_valid=0, x_data holds its last value; it is not zeroed except by reset.
- en=0: in_ready=0 and no loads occur. Outputs continue to drain normally.
- en toggling mid-stall: acceptance occurs on the first edge where en=1 and the destination is free or draining.
- word_cnt wraps modulo 2^CNT_W (255 -> 0), with no saturation and no flag.
- ready_i inputs on channels with valid_q=0 are ignored.

Optional Feature:
- Macro: DEMUX_RR_EN.
- Defined:
  - sel is ignored (port retained, unused).
  - dst = rr_q, a 2-bit pointer reset to 0 that increments mod 4 (3 -> 0) on every accept.
  - If the target channel is full and not draining, in_ready=0 and rr_q does not advance; there is no skipping.
- Undefined: rr_q is not instantiated; dst = sel.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, then rst=0 -> all x_valid=0, all x_data=0, word_cnt=0, in_ready=1 with en=1.
- Basic steer: en=1, all x_ready=0; send 4'h5 with sel=0, 4'h4 sel=1, 4'h6 sel=2, 4'hB sel=3 on consecutive cycles -> each valid rises one cycle after its accept; a/b/c/d_data = 5/4/6/B; word_cnt=4.
- Backpressure: channel A full, a_ready=0; send 4'h9 with sel=0 -> in_ready=0, a_data stays 5. Raise a_ready -> same edge drains 5 and loads 9; a_valid stays 1, a_data=9 next cycle.
- Enable gating: en=0 with in_valid=1, sel=2, c empty -> in_ready=0, no load, word_cnt unchanged. Meanwhile d_ready=1 drains D (d_valid 1 -> 0).
- Reset mid-operation plus counter wrap:
  - Preload word_cnt to 255 via 255 accepts with all x_ready=1; the next accept -> word_cnt=0.
  - Fill A and C, then assert rst for one cycle -> a_valid=c_valid=0, word_cnt=0 after the edge.
- DEMUX_RR_EN build: sel held at 3, all x_ready=1; send 1, 2, 3, 4, 5 -> words land on A, B, C, D, A. Block A (a_ready=0, A full) -> in_ready=0 while rr_q=0 and the pointer does not advance.

Source files
------------

// File: rtl/demux_1x4_buf_if.sv
// demux_1x4_buf_if: shared input valid/ready plus four buffered output channels of demux_1x4_buf.
interface demux_1x4_buf_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       sel;
    logic             en;
    logic [WIDTH-1:0] a_data, b_data, c_data, d_data;
    logic             a_valid, b_valid, c_valid, d_valid;
    logic             a_ready, b_ready, c_ready, d_ready;
    logic [CNT_W-1:0] word_cnt;

    modport master (
        output in_data, in_valid, sel, en, a_ready, b_ready, c_ready, d_ready,
        input  in_ready, a_data, b_data, c_data, d_data,
        input  a_valid, b_valid, c_valid, d_valid, word_cnt
    );

    modport slave (
        input  in_data, in_valid, sel, en, a_ready, b_ready, c_ready, d_ready,
        output in_ready, a_data, b_data, c_data, d_data,
        output a_valid, b_valid, c_valid, d_valid, word_cnt
    );
endinterface

// File: rtl/demux_1x4_buf.sv
// demux_1x4_buf: registered 1-to-4 demux into single-entry buffers with an accepted-word counter.
// Define DEMUX_RR_EN to steer round-robin (sel ignored) instead of by sel.
module demux_1x4_buf #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input logic clk,
    input logic rst,
    demux_1x4_buf_if.slave bus
);
    logic [WIDTH-1:0] r_data [4];
    logic [3:0]       r_valid;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       w_rdy;
    logic [1:0]       w_dst;
    logic             w_acc;

    assign w_rdy = {bus.d_ready, bus.c_ready, bus.b_ready, bus.a_ready};
`ifdef DEMUX_RR_EN
    logic [1:0] r_rr;
    assign w_dst = r_rr;
    always_ff @(posedge clk)
        if (rst)
            r_rr <= '0;
        else if (w_acc)
            r_rr <= r_rr + 2'd1;
`else
    assign w_dst = bus.sel;
`endif
    assign bus.in_ready = bus.en & (~r_valid[w_dst] | w_rdy[w_dst]);
    assign w_acc        = bus.in_valid & bus.in_ready;

    // a load wins over a drain on the same channel, keeping 1 word/cycle throughput
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            r_cnt   <= '0;
            for (int i = 0; i < 4; i++)
                r_data[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++)
                if (w_acc && w_dst == 2'(i)) begin
                    r_data[i]  <= bus.in_data;
                    r_valid[i] <= 1'b1;
                end else if (w_rdy[i])
                    r_valid[i] <= 1'b0;
            if (w_acc)
                r_cnt <= r_cnt + 1'b1;
        end
    end

    assign bus.a_data   = r_data[0];
    assign bus.b_data   = r_data[1];
    assign bus.c_data   = r_data[2];
    assign bus.d_data   = r_data[3];
    assign bus.a_valid  = r_valid[0];
    assign bus.b_valid  = r_valid[1];
    assign bus.c_valid  = r_valid[2];
    assign bus.d_valid  = r_valid[3];
    assign bus.word_cnt = r_cnt;
endmodule

// File: tb/tb_demux_1x4_buf.sv
// tb_demux_1x4_buf: table vectors, corner sequences and random stimulus against a reference model.
module tb_demux_1x4_buf;
    localparam int W  = 4;
    localparam int CW = 8;

    logic clk = 1'b0;
    logic rst;
    logic [3:0] rdy;
    always #5 clk = ~clk;

    demux_1x4_buf_if #(.WIDTH(W), .CNT_W(CW)) bus();
    demux_1x4_buf #(.WIDTH(W), .CNT_W(CW)) dut (.clk(clk), .rst(rst), .bus(bus));

    assign {bus.d_ready, bus.c_ready, bus.b_ready, bus.a_ready} = rdy;

    int tests = 0;
    int fails = 0;
    logic [W-1:0] md [4];
    logic [3:0]   mv;
    int           mcnt;
    int           mrr;

    wire [3:0]     dv = {bus.d_valid, bus.c_valid, bus.b_valid, bus.a_valid};
    wire [4*W-1:0] dd = {bus.d_data, bus.c_data, bus.b_data, bus.a_data};

    typedef struct {
        logic        vld;
        logic [3:0]  d;
        logic [1:0]  s;
        logic        e;
        logic [3:0]  r;
        logic        er;
        logic [3:0]  ev;
        logic [15:0] edt;
        int          ec;
    } vec_t;
    vec_t tv [10];

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    function automatic int mdst();
`ifdef DEMUX_RR_EN
        return mrr;
`else
        return int'(bus.sel);
`endif
    endfunction

    task automatic check_outs(input string n);
        chk({n, " valid"}, 32'(dv), 32'(mv));
        for (int i = 0; i < 4; i++)
            chk($sformatf("%s data%0d", n, i), 32'(dd[i*W +: W]), 32'(md[i]));
        chk({n, " word_cnt"}, 32'(bus.word_cnt), 32'(mcnt));
    endtask

    // Called at a negedge: drive, check in_ready, advance model at posedge, check outputs at next negedge.
    task automatic apply(input logic vld, input logic [3:0] d, input logic [1:0] s,
                         input logic e, input logic [3:0] r, output logic got_rdy);
        int  t;
        logic acc;
        bus.in_valid = vld;
        bus.in_data  = d;
        bus.sel      = s;
        bus.en       = e;
        rdy          = r;
        #1;
        t   = mdst();
        acc = e && (!mv[t] || r[t]);
        got_rdy = bus.in_ready;
        chk("in_ready", 32'(bus.in_ready), 32'(acc));
        @(posedge clk);
        for (int i = 0; i < 4; i++)
            if (mv[i] && r[i]) mv[i] = 1'b0;
        if (vld && acc) begin
            md[t] = d;
            mv[t] = 1'b1;
            mcnt  = (mcnt + 1) % 256;
            mrr   = (mrr + 1) % 4;
        end
        @(negedge clk);
        check_outs("model");
    endtask

    task automatic do_reset(input int n);
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.sel      = '0;
        bus.en       = 1'b1;
        rdy          = '0;
        repeat (n) @(negedge clk);
        rst  = 1'b0;
        mv   = '0;
        mcnt = 0;
        mrr  = 0;
        for (int i = 0; i < 4; i++) md[i] = '0;
        #1;
        check_outs("reset");
        chk("reset in_ready", 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        logic g;
        int   guard;
        // {vld, data, sel, en, rdy{d,c,b,a}, exp in_ready, exp valid{d,c,b,a}, exp data{d,c,b,a}, exp cnt}
        tv[0] = '{1'b1, 4'h5, 2'd0, 1'b1, 4'b0000, 1'b1, 4'b0001, 16'h0005, 1};
        tv[1] = '{1'b1, 4'h4, 2'd1, 1'b1, 4'b0000, 1'b1, 4'b0011, 16'h0045, 2};
        tv[2] = '{1'b1, 4'h6, 2'd2, 1'b1, 4'b0000, 1'b1, 4'b0111, 16'h0645, 3};
        tv[3] = '{1'b1, 4'hB, 2'd3, 1'b1, 4'b0000, 1'b1, 4'b1111, 16'hB645, 4};
        tv[4] = '{1'b1, 4'h9, 2'd0, 1'b1, 4'b0000, 1'b0, 4'b1111, 16'hB645, 4};
        tv[5] = '{1'b1, 4'h9, 2'd0, 1'b1, 4'b0001, 1'b1, 4'b1111, 16'hB649, 5};
        tv[6] = '{1'b0, 4'h0, 2'd2, 1'b1, 4'b0100, 1'b1, 4'b1011, 16'hB649, 5};
        tv[7] = '{1'b1, 4'h7, 2'd2, 1'b0, 4'b1000, 1'b0, 4'b0011, 16'hB649, 5};
        tv[8] = '{1'b1, 4'h7, 2'd2, 1'b1, 4'b0000, 1'b1, 4'b0111, 16'hB749, 6};
        tv[9] = '{1'b0, 4'h0, 2'd0, 1'b1, 4'b1111, 1'b1, 4'b0000, 16'hB749, 6};

        @(negedge clk);
        do_reset(2);

`ifndef DEMUX_RR_EN
        for (int k = 0; k < 10; k++) begin
            apply(tv[k].vld, tv[k].d, tv[k].s, tv[k].e, tv[k].r, g);
            chk($sformatf("vec%0d in_ready", k), 32'(g), 32'(tv[k].er));
            chk($sformatf("vec%0d valid", k), 32'(dv), 32'(tv[k].ev));
            chk($sformatf("vec%0d data", k), 32'(dd), 32'(tv[k].edt));
            chk($sformatf("vec%0d word_cnt", k), 32'(bus.word_cnt), 32'(tv[k].ec));
        end
`else
        do_reset(1);
        for (int k = 1; k <= 5; k++) begin
            apply(1'b1, 4'(k), 2'd3, 1'b1, 4'b1111, g);
            chk($sformatf("rr word%0d", k), 32'(dd[((k - 1) % 4)*W +: W]), 32'(k));
        end
        for (int k = 6; k <= 8; k++)
            apply(1'b1, 4'(k), 2'd3, 1'b1, 4'b1110, g);
        for (int k = 0; k < 2; k++) begin
            apply(1'b1, 4'h9, 2'd3, 1'b1, 4'b1110, g);
            chk("rr blocked", 32'(g), 32'd0);
        end
        apply(1'b1, 4'h9, 2'd3, 1'b1, 4'b1111, g);
        chk("rr unblock a_data", 32'(bus.a_data), 32'h9);
`endif

        guard = 0;
        while (mcnt != 255 && guard < 600) begin
            apply(1'b1, 4'($urandom), 2'($urandom), 1'b1, 4'b1111, g);
            guard++;
        end
        chk("cnt at 255", 32'(bus.word_cnt), 32'd255);
        apply(1'b1, 4'hE, 2'd1, 1'b1, 4'b1111, g);
        chk("cnt wrap", 32'(bus.word_cnt), 32'd0);

        do_reset(1);
        apply(1'b1, 4'h3, 2'd0, 1'b1, 4'b0000, g);
        apply(1'b1, 4'hC, 2'd2, 1'b1, 4'b0000, g);
        do_reset(1);
        chk("mid reset valid", 32'(dv), 32'd0);
        chk("mid reset cnt", 32'(bus.word_cnt), 32'd0);

        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 59) == 0)
                do_reset(1);
            else
                apply(1'($urandom), 4'($urandom), 2'($urandom),
                      $urandom_range(0, 4) != 0, 4'($urandom), g);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
